// File: rtl/sensor_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_frame_gen
//  Description : Packs a narrow pattern stream into wide beats and emits
//                framed AXI-Stream packets: one header beat, a programmable
//                number of data beats, then a programmable idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_gen #(
    parameter int PATTERN_WIDTH = 32,
    parameter int OUT_WIDTH     = 512
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_ENABLE,
    input  logic [15:0]              i_FRAME_BEATS,
    input  logic [15:0]              i_GAP_CYCLES,
    output logic [31:0]              o_FRAME_COUNT,
    output logic                     o_BUSY,
    input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic                     AXIS_IN_TVALID,
    output logic                     AXIS_IN_TREADY,
    output logic [OUT_WIDTH-1:0]     AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    output logic                     AXIS_OUT_TLAST,
    input  logic                     AXIS_OUT_TREADY
);

    localparam int                  c_RATIO     = OUT_WIDTH / PATTERN_WIDTH;
    localparam int                  c_SLOT_W    = $clog2(c_RATIO);
    localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(c_RATIO - 1);
    localparam logic [31:0]         c_MAGIC     = 32'hA5A5_5A5A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Frame configuration captured when the header is loaded
    logic [15:0]           r_fb;
    logic [15:0]           r_gap;
    logic [15:0]           r_gap_ctr;

    // Beats completed into the output register / beats handed downstream
    logic [15:0]           r_pack_count;
    logic [15:0]           r_send_count;

    logic [c_SLOT_W-1:0]   r_slot;
    logic [OUT_WIDTH-1:0]  r_gather;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic                  r_out_valid;
    logic [31:0]           r_frame_count;

    logic [15:0]           w_fb_eff;
    logic [OUT_WIDTH-1:0]  w_header;
    logic [OUT_WIDTH-1:0]  w_beat;
    logic                  w_last_slot;
    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_out_last;

    // Header image and the completed beat (gather plus the arriving pattern)
    always_comb begin
        w_fb_eff        = (i_FRAME_BEATS == 16'd0) ? 16'd1 : i_FRAME_BEATS;
        w_header        = '0;
        w_header[31:0]  = c_MAGIC;
        w_header[63:32] = r_frame_count;
        w_header[79:64] = w_fb_eff;
        w_beat          = r_gather;
        w_beat[(c_RATIO-1)*PATTERN_WIDTH +: PATTERN_WIDTH] = AXIS_IN_TDATA;
    end

    // The last pattern of a beat may only be taken if the output register
    // is empty or draining this cycle; earlier slots only touch the gather.
    assign w_last_slot = (r_slot == c_LAST_SLOT);
    assign w_in_ready  = (r_state == ST_DATA) && (r_pack_count < r_fb) &&
                         (!w_last_slot || !r_out_valid || AXIS_OUT_TREADY);
    assign w_in_fire   = w_in_ready && AXIS_IN_TVALID;
    assign w_out_fire  = r_out_valid && AXIS_OUT_TREADY;
    assign w_out_last  = (r_state == ST_DATA) && r_out_valid &&
                         (r_send_count == r_fb - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_ENABLE) begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_out_fire) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_out_fire && w_out_last) begin
                    w_state_next = (r_gap == 16'd0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_ctr <= 16'd1) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: header load, packing, output register, counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fb          <= '0;
            r_gap         <= '0;
            r_gap_ctr     <= '0;
            r_pack_count  <= '0;
            r_send_count  <= '0;
            r_slot        <= '0;
            r_gather      <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ENABLE) begin
                        r_fb        <= w_fb_eff;
                        r_gap       <= i_GAP_CYCLES;
                        r_out_data  <= w_header;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (w_out_fire) begin
                        r_out_valid  <= 1'b0;
                        r_pack_count <= '0;
                        r_send_count <= '0;
                        r_slot       <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_out_fire) begin
                        r_out_valid  <= 1'b0;
                        r_send_count <= r_send_count + 16'd1;
                        if (w_out_last) begin
                            r_frame_count <= r_frame_count + 32'd1;
                            r_gap_ctr     <= r_gap;
                        end
                    end
                    // A completing beat overrides the drain above, so the
                    // output register refills in the same cycle it empties.
                    if (w_in_fire) begin
                        if (w_last_slot) begin
                            r_out_data   <= w_beat;
                            r_out_valid  <= 1'b1;
                            r_slot       <= '0;
                            r_pack_count <= r_pack_count + 16'd1;
                        end else begin
                            r_gather[r_slot*PATTERN_WIDTH +: PATTERN_WIDTH] <= AXIS_IN_TDATA;
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_ctr <= r_gap_ctr - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign AXIS_IN_TREADY  = w_in_ready;
    assign AXIS_OUT_TDATA  = r_out_data;
    assign AXIS_OUT_TVALID = r_out_valid;
    assign AXIS_OUT_TLAST  = w_out_last;
    assign o_FRAME_COUNT   = r_frame_count;
    assign o_BUSY          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
